seg7_time_decoder: RTL and testbench

//  Receive-side counterpart of the stopwatch display path: samples the four 7-segment buses (A..D),

---
 rtl/stopwatch_pkg.sv | 37 +++
 rtl/seg7_digit_decode.sv | 28 ++
 rtl/seg7_time_decoder.sv | 209 ++++++++++++++++++++
 tb/tb_seg7_time_decoder.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch display path: segment patterns, widths,
// readback FSM states and the BCD-to-binary helper.
package stopwatch_pkg;

  localparam int DIGIT_W = 4;
  localparam int VALUE_W = 13;
  localparam int SEG_W   = 7;

  // Segment order bit6=a .. bit0=g, active-high
  localparam logic [SEG_W-1:0] SEG_0 = 7'h7E;
  localparam logic [SEG_W-1:0] SEG_1 = 7'h30;
  localparam logic [SEG_W-1:0] SEG_2 = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_3 = 7'h79;
  localparam logic [SEG_W-1:0] SEG_4 = 7'h33;
  localparam logic [SEG_W-1:0] SEG_5 = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_6 = 7'h5F;
  localparam logic [SEG_W-1:0] SEG_7 = 7'h70;
  localparam logic [SEG_W-1:0] SEG_8 = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9 = 7'h7B;

  typedef enum logic [1:0] {
    ST_UNSYNC  = 2'd0,
    ST_SYNCING = 2'd1,
    ST_LOCKED  = 2'd2
  } sync_state_e;

  function automatic logic [VALUE_W-1:0] bcd_to_value(
    input logic [DIGIT_W-1:0] a,
    input logic [DIGIT_W-1:0] b,
    input logic [DIGIT_W-1:0] c,
    input logic [DIGIT_W-1:0] d
  );
    return (VALUE_W'(a) * 13'd1000) + (VALUE_W'(b) * 13'd100) +
           (VALUE_W'(c) * 13'd10) + VALUE_W'(d);
  endfunction

endpackage

// File: rtl/seg7_digit_decode.sv
// Combinational 7-segment to BCD decoder; only exact patterns are accepted.
module seg7_digit_decode
  import stopwatch_pkg::*;
(
  input  logic [SEG_W-1:0]   seg_i,
  output logic [DIGIT_W-1:0] digit_o,
  output logic               valid_o
);

  always_comb begin
    digit_o = 4'd0;
    valid_o = 1'b1;
    case (seg_i)
      SEG_0:   digit_o = 4'd0;
      SEG_1:   digit_o = 4'd1;
      SEG_2:   digit_o = 4'd2;
      SEG_3:   digit_o = 4'd3;
      SEG_4:   digit_o = 4'd4;
      SEG_5:   digit_o = 4'd5;
      SEG_6:   digit_o = 4'd6;
      SEG_7:   digit_o = 4'd7;
      SEG_8:   digit_o = 4'd8;
      SEG_9:   digit_o = 4'd9;
      default: valid_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_time_decoder.sv
// Readback monitor for the stopwatch display: samples four segment buses, rebuilds
// the count and classifies each frame as hold / step / wrap / clear / error.
module seg7_time_decoder
  import stopwatch_pkg::*;
#(
  parameter int MAX_COUNT   = 5999,
  parameter int SYNC_FRAMES = 2,
  parameter int ERR_W       = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [SEG_W-1:0]   seg_a,
  input  logic [SEG_W-1:0]   seg_b,
  input  logic [SEG_W-1:0]   seg_c,
  input  logic [SEG_W-1:0]   seg_d,
  input  logic               clr_err,
  output logic [VALUE_W-1:0] value,
  output logic               value_vld,
  output logic               step,
  output logic               wrap,
  output logic               clr_seen,
  output logic               seg_err,
  output logic               jump_err,
  output logic               locked,
  output logic [ERR_W-1:0]   err_count
);

  localparam int CNT_W = (SYNC_FRAMES < 2) ? 1 : $clog2(SYNC_FRAMES + 1);
  localparam logic [VALUE_W-1:0] MAX_V = VALUE_W'(MAX_COUNT);

  // S0: raw segment capture; the valid bit keeps reset-time garbage out of S2
  logic [SEG_W-1:0] seg_a_q, seg_b_q, seg_c_q, seg_d_q;
  logic             s0_vld_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      seg_a_q  <= 7'd0;
      seg_b_q  <= 7'd0;
      seg_c_q  <= 7'd0;
      seg_d_q  <= 7'd0;
      s0_vld_q <= 1'b0;
    end else begin
      seg_a_q  <= seg_a;
      seg_b_q  <= seg_b;
      seg_c_q  <= seg_c;
      seg_d_q  <= seg_d;
      s0_vld_q <= 1'b1;
    end
  end

  logic [DIGIT_W-1:0] dig_a_s, dig_b_s, dig_c_s, dig_d_s;
  logic               ok_a_s, ok_b_s, ok_c_s, ok_d_s;

  seg7_digit_decode u_dec_a (.seg_i(seg_a_q), .digit_o(dig_a_s), .valid_o(ok_a_s));
  seg7_digit_decode u_dec_b (.seg_i(seg_b_q), .digit_o(dig_b_s), .valid_o(ok_b_s));
  seg7_digit_decode u_dec_c (.seg_i(seg_c_q), .digit_o(dig_c_s), .valid_o(ok_c_s));
  seg7_digit_decode u_dec_d (.seg_i(seg_d_q), .digit_o(dig_d_s), .valid_o(ok_d_s));

  logic [DIGIT_W-1:0] dig_a_q, dig_b_q, dig_c_q, dig_d_q;
  logic               frame_ok_q, s1_vld_q;
  logic               frame_ok_d;

  always_comb begin
    frame_ok_d = ok_a_s & ok_b_s & ok_c_s & ok_d_s & (dig_a_s <= 4'd5);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dig_a_q    <= 4'd0;
      dig_b_q    <= 4'd0;
      dig_c_q    <= 4'd0;
      dig_d_q    <= 4'd0;
      frame_ok_q <= 1'b0;
      s1_vld_q   <= 1'b0;
    end else begin
      dig_a_q    <= dig_a_s;
      dig_b_q    <= dig_b_s;
      dig_c_q    <= dig_c_s;
      dig_d_q    <= dig_d_s;
      frame_ok_q <= frame_ok_d;
      s1_vld_q   <= s0_vld_q;
    end
  end

  // S2: value_q doubles as the previous value, since it only moves on valid frames
  sync_state_e        state_q, state_d;
  logic [CNT_W-1:0]   sync_cnt_q, sync_cnt_d;
  logic [VALUE_W-1:0] value_q, value_d, cur_value_s;
  logic               value_vld_q, value_vld_d;
  logic               step_q, step_d, wrap_q, wrap_d, clr_seen_q, clr_seen_d;
  logic               seg_err_q, seg_err_d, jump_err_q, jump_err_d;
  logic               locked_q, locked_d;
  logic [ERR_W-1:0]   err_count_q, err_count_d;
  logic               is_hold_s, is_inc_s, is_wrap_s, is_zero_s, is_legal_s;

  always_comb begin
    cur_value_s = bcd_to_value(dig_a_q, dig_b_q, dig_c_q, dig_d_q);
    is_hold_s   = (cur_value_s == value_q);
    is_inc_s    = (cur_value_s == (value_q + 13'd1));
    is_zero_s   = (cur_value_s == 13'd0);
    is_wrap_s   = (value_q == MAX_V) && is_zero_s;
    is_legal_s  = is_hold_s | is_inc_s | is_wrap_s | is_zero_s;

    state_d     = state_q;
    sync_cnt_d  = sync_cnt_q;
    value_d     = value_q;
    value_vld_d = value_vld_q;
    step_d      = 1'b0;
    wrap_d      = 1'b0;
    clr_seen_d  = 1'b0;
    seg_err_d   = 1'b0;
    jump_err_d  = 1'b0;

    if (!s1_vld_q) begin
      value_vld_d = 1'b0;
    end else if (!frame_ok_q) begin
      seg_err_d   = 1'b1;
      value_vld_d = 1'b0;
      state_d     = ST_UNSYNC;
      sync_cnt_d  = '0;
    end else begin
      value_d     = cur_value_s;
      value_vld_d = 1'b1;
      case (state_q)
        ST_UNSYNC: begin
          sync_cnt_d = CNT_W'(1);
          state_d    = (SYNC_FRAMES <= 1) ? ST_LOCKED : ST_SYNCING;
        end
        ST_SYNCING: begin
          if (is_legal_s) begin
            sync_cnt_d = sync_cnt_q + CNT_W'(1);
            state_d    = ((int'(sync_cnt_q) + 1) >= SYNC_FRAMES) ? ST_LOCKED : ST_SYNCING;
          end else begin
            sync_cnt_d = CNT_W'(1);
            state_d    = ST_SYNCING;
          end
        end
        ST_LOCKED: begin
          // wrap must be tested before the generic zero case
          if (is_hold_s) begin
            state_d = ST_LOCKED;
          end else if (is_inc_s) begin
            step_d = 1'b1;
          end else if (is_wrap_s) begin
            step_d = 1'b1;
            wrap_d = 1'b1;
          end else if (is_zero_s) begin
            clr_seen_d = 1'b1;
          end else begin
            jump_err_d = 1'b1;
          end
        end
        default: begin
          state_d    = ST_UNSYNC;
          sync_cnt_d = '0;
        end
      endcase
    end

    locked_d = (state_d == ST_LOCKED);

    if (clr_err) begin
      err_count_d = {ERR_W{1'b0}};
    end else if ((seg_err_d | jump_err_d) && (err_count_q != {ERR_W{1'b1}})) begin
      err_count_d = err_count_q + {{(ERR_W-1){1'b0}}, 1'b1};
    end else begin
      err_count_d = err_count_q;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_UNSYNC;
      sync_cnt_q  <= '0;
      value_q     <= 13'd0;
      value_vld_q <= 1'b0;
      step_q      <= 1'b0;
      wrap_q      <= 1'b0;
      clr_seen_q  <= 1'b0;
      seg_err_q   <= 1'b0;
      jump_err_q  <= 1'b0;
      locked_q    <= 1'b0;
      err_count_q <= {ERR_W{1'b0}};
    end else begin
      state_q     <= state_d;
      sync_cnt_q  <= sync_cnt_d;
      value_q     <= value_d;
      value_vld_q <= value_vld_d;
      step_q      <= step_d;
      wrap_q      <= wrap_d;
      clr_seen_q  <= clr_seen_d;
      seg_err_q   <= seg_err_d;
      jump_err_q  <= jump_err_d;
      locked_q    <= locked_d;
      err_count_q <= err_count_d;
    end
  end

  assign value     = value_q;
  assign value_vld = value_vld_q;
  assign step      = step_q;
  assign wrap      = wrap_q;
  assign clr_seen  = clr_seen_q;
  assign seg_err   = seg_err_q;
  assign jump_err  = jump_err_q;
  assign locked    = locked_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_seg7_time_decoder.sv
// Table-driven bench for seg7_time_decoder with a 3-deep expectation queue
// matching the frame pipeline, plus hand sequences for counter and reset corners.
module tb_seg7_time_decoder;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [6:0]  seg_a = 7'd0, seg_b = 7'd0, seg_c = 7'd0, seg_d = 7'd0;
  logic        clr_err = 1'b0;
  logic [12:0] value;
  logic        value_vld, step, wrap, clr_seen, seg_err, jump_err, locked;
  logic [7:0]  err_count;

  seg7_time_decoder dut (
    .clock(clock), .reset(reset),
    .seg_a(seg_a), .seg_b(seg_b), .seg_c(seg_c), .seg_d(seg_d),
    .clr_err(clr_err),
    .value(value), .value_vld(value_vld), .step(step), .wrap(wrap),
    .clr_seen(clr_seen), .seg_err(seg_err), .jump_err(jump_err),
    .locked(locked), .err_count(err_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [27:0] pats;
    logic [27:0] exp;
    bit          chk;
    int          idx;
  } vec_t;

  vec_t tv[27];
  vec_t q[$];
  int   checks = 0;
  int   errors = 0;

  logic [27:0] act;
  assign act = {value, value_vld, step, wrap, clr_seen, seg_err, jump_err, locked, err_count};

  function automatic logic [6:0] enc(input int d);
    case (d)
      0: return 7'h7E;  1: return 7'h30;  2: return 7'h6D;  3: return 7'h79;
      4: return 7'h33;  5: return 7'h5B;  6: return 7'h5F;  7: return 7'h70;
      8: return 7'h7F;  9: return 7'h7B;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [27:0] frame_pats(input int n);
    return {enc(n / 1000), enc((n / 100) % 10), enc((n / 10) % 10), enc(n % 10)};
  endfunction

  // {value, vld, step, wrap, clr_seen, seg_err, jump_err, locked, err_count}
  function automatic logic [27:0] ex(input int v, input bit vld, input bit st, input bit wr,
                                     input bit cl, input bit se, input bit je, input bit lk,
                                     input int ec);
    return {13'(v), vld, st, wr, cl, se, je, lk, 8'(ec)};
  endfunction

  function automatic vec_t row(input int n, input logic [27:0] e);
    vec_t v;
    v.pats = frame_pats(n);
    v.exp  = e;
    v.chk  = 1'b1;
    v.idx  = 0;
    return v;
  endfunction

  task automatic check(input string name, input logic [27:0] a, input logic [27:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, a, e);
    end
  endtask

  task automatic step_frame(input logic [27:0] pats, input logic [27:0] e, input bit chk,
                            input int idx);
    vec_t v;
    @(negedge clock);
    if (q.size() == 3) begin
      v = q.pop_front();
      if (v.chk) check($sformatf("frame%0d", v.idx), act, v.exp);
    end
    reset = 1'b1;
    {seg_a, seg_b, seg_c, seg_d} = pats;
    v.pats = pats;
    v.exp  = e;
    v.chk  = chk;
    v.idx  = idx;
    q.push_back(v);
  endtask

  initial begin
    tv[0]  = row(0,    ex(0,    1, 0, 0, 0, 0, 0, 0, 0));
    tv[1]  = row(0,    ex(0,    1, 0, 0, 0, 0, 0, 1, 0));
    tv[2]  = row(0,    ex(0,    1, 0, 0, 0, 0, 0, 1, 0));
    tv[3]  = row(1,    ex(1,    1, 1, 0, 0, 0, 0, 1, 0));
    tv[4]  = row(0,    ex(0,    1, 0, 0, 1, 0, 0, 1, 0));
    tv[5]  = row(0,    ex(0,    0, 0, 0, 0, 1, 0, 0, 1));
    tv[5].pats[27:21] = 7'h5F;
    tv[6]  = row(419,  ex(419,  1, 0, 0, 0, 0, 0, 0, 1));
    tv[7]  = row(419,  ex(419,  1, 0, 0, 0, 0, 0, 1, 1));
    tv[8]  = row(420,  ex(420,  1, 1, 0, 0, 0, 0, 1, 1));
    tv[9]  = row(5999, ex(5999, 1, 0, 0, 0, 0, 1, 1, 2));
    tv[10] = row(0,    ex(0,    1, 1, 1, 0, 0, 0, 1, 2));
    tv[11] = row(0,    ex(0,    1, 0, 0, 0, 0, 0, 1, 2));
    tv[12] = row(1234, ex(1234, 1, 0, 0, 0, 0, 1, 1, 3));
    tv[13] = row(1236, ex(1236, 1, 0, 0, 0, 0, 1, 1, 4));
    tv[14] = row(1237, ex(1237, 1, 1, 0, 0, 0, 0, 1, 4));
    tv[15] = row(1237, ex(1237, 0, 0, 0, 0, 1, 0, 0, 5));
    tv[15].pats[13:7] = 7'h00;
    tv[16] = row(500,  ex(500,  1, 0, 0, 0, 0, 0, 0, 5));
    tv[17] = row(502,  ex(502,  1, 0, 0, 0, 0, 0, 0, 5));
    tv[18] = row(503,  ex(503,  1, 0, 0, 0, 0, 0, 1, 5));
    tv[19] = row(503,  ex(503,  0, 0, 0, 0, 1, 0, 0, 6));
    tv[19].pats[6:0] = 7'h7C;
    tv[20] = row(503,  ex(503,  1, 0, 0, 0, 0, 0, 0, 6));
    tv[21] = row(9999, ex(503,  0, 0, 0, 0, 1, 0, 0, 7));
    tv[22] = row(5999, ex(5999, 1, 0, 0, 0, 0, 0, 0, 7));
    tv[23] = row(0,    ex(0,    1, 0, 0, 0, 0, 0, 1, 7));
    tv[24] = row(0,    ex(0,    1, 0, 0, 0, 0, 0, 1, 7));
    tv[25] = row(5678, ex(5678, 1, 0, 0, 0, 0, 1, 1, 8));
    tv[26] = row(5679, ex(5679, 1, 1, 0, 0, 0, 0, 1, 8));

    repeat (2) @(negedge clock);
    check("reset_state", act, 28'd0);

    for (int i = 0; i < 27; i++) step_frame(tv[i].pats, tv[i].exp, 1'b1, i + 1);
    for (int i = 0; i < 3; i++)
      step_frame(frame_pats(5679), ex(5679, 1, 0, 0, 0, 0, 0, 1, 8), 1'b1, 28 + i);

    // Saturation: 250 blank frames push err_count from 8 past all-ones
    for (int i = 0; i < 250; i++) step_frame(28'd0, 28'd0, 1'b0, 0);
    for (int i = 0; i < 3; i++) step_frame(frame_pats(0), 28'd0, 1'b0, 0);
    check("err_saturate", {20'd0, err_count}, 28'hFF);
    q.delete();

    clr_err = 1'b1;
    @(negedge clock);
    clr_err = 1'b0;
    check("err_clear", {20'd0, err_count}, 28'd0);

    // Clear arriving in the same cycle as an error event must win
    {seg_a, seg_b, seg_c, seg_d} = 28'd0;
    @(negedge clock);
    {seg_a, seg_b, seg_c, seg_d} = frame_pats(0);
    @(negedge clock);
    clr_err = 1'b1;
    @(negedge clock);
    clr_err = 1'b0;
    check("clr_vs_evt_seg_err", {27'd0, seg_err}, 28'd1);
    check("clr_vs_evt_count", {20'd0, err_count}, 28'd0);

    // Async reset mid-run with the pipeline full of valid frames
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("midrun_reset", act, 28'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("post_reset_c1", act, 28'd0);
    @(negedge clock);
    check("post_reset_c2", act, 28'd0);
    @(negedge clock);
    check("post_reset_c3", act, ex(0, 1, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clock);
    check("post_reset_c4", act, ex(0, 1, 0, 0, 0, 0, 0, 1, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
